// File: rtl/shuffle_pkg.sv
// shuffle_pkg: shared types and constants for the RC4 key-scheduling shuffle
// engine (shuffle_responder and its key_byte_select helper).
package shuffle_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] LAST_INDEX = 8'd255;

    // Key index width: wide enough for KEY_BYTES up to 16.
    localparam int KIDX_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        RD_J,
        WT_J,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } shuffle_state_t;

endpackage

// File: rtl/key_byte_select.sv
// key_byte_select: picks key byte k out of the latched secret key.
// Byte 0 is the most significant byte of the key vector.
// Ports:
//   key      in  8*KEY_BYTES  latched secret key
//   k        in  KIDX_W       key byte index (0..KEY_BYTES-1)
//   key_byte out 8            selected byte
module key_byte_select
    import shuffle_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [KIDX_W-1:0]      k,
    output logic [DATA_W-1:0]      key_byte
);

    always_comb begin
        key_byte = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (k == KIDX_W'(n)) begin
                key_byte = key[8*(KEY_BYTES-1-n) +: 8];
            end
        end
    end

endmodule

// File: rtl/shuffle_responder.sv
// shuffle_responder: RC4 key-scheduling swap loop over the S-array RAM.
// On start (sampled in IDLE) it runs 256 iterations of
//   j = j + s[i] + key[i mod KEY_BYTES]; swap s[i], s[j]
// and then pulses finish for one cycle.
// Optional feature: define SHUFFLE_SKIP_SELF_SWAP_EN to skip the two
// writes of any iteration where j == i.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   request pulse (IDLE only)
//   secret_key   in   8*KEY_BYTES key, captured at accept
//   read_data    in   RAM q, valid the cycle after the address
//   address      out  RAM address
//   write_data   out  RAM write data
//   write_enable out  RAM write strobe
//   finish       out  one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RD_I  | present i to RAM
// WT_I  | s[i] on q; capture si, update j
// RD_J  | present new j to RAM
// WT_J  | s[j] on q; capture sj
// WR_I  | write sj to s[i]
// WR_J  | write si to s[j]
// NEXT  | advance i and k, or finish after i == 255
// DONE  | finish pulse
module shuffle_responder
    import shuffle_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [DATA_W-1:0]      read_data,
    output logic [ADDR_W-1:0]      address,
    output logic [DATA_W-1:0]      write_data,
    output logic                   write_enable,
    output logic                   finish
);

    localparam logic [KIDX_W-1:0] K_LAST = KIDX_W'(KEY_BYTES - 1);

    shuffle_state_t state, next_state;

    logic [ADDR_W-1:0]      i, j;
    logic [DATA_W-1:0]      si, sj;
    logic [KIDX_W-1:0]      k;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [DATA_W-1:0]      key_byte;

    key_byte_select #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .key      (key_q),
        .k        (k),
        .key_byte (key_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RD_I;
            RD_I: next_state = WT_I;
            WT_I: next_state = RD_J;
            RD_J: next_state = WT_J;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
            WT_J: next_state = (j == i) ? NEXT : WR_I;
`else
            WT_J: next_state = WR_I;
`endif
            WR_I: next_state = WR_J;
            WR_J: next_state = NEXT;
            NEXT: next_state = (i == LAST_INDEX) ? DONE : RD_I;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            key_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        key_q <= secret_key;
                    end
                end
                WT_I: begin
                    si <= read_data;
                    j  <= j + read_data + key_byte;
                end
                WT_J: sj <= read_data;
                NEXT: begin
                    if (i != LAST_INDEX) begin
                        i <= i + 8'd1;
                        // Wrapping key index by compare, not by modulo.
                        k <= (k == K_LAST) ? '0 : k + KIDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        finish       = 1'b0;
        case (state)
            RD_I, WT_I, NEXT: address = i;
            RD_J, WT_J:       address = j;
            WR_I: begin
                address      = i;
                write_data   = sj;
                write_enable = 1'b1;
            end
            WR_J: begin
                address      = j;
                write_data   = si;
                write_enable = 1'b1;
            end
            DONE: finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shuffle_responder.sv
// Directed testbench for shuffle_responder (KEY_BYTES=3 and KEY_BYTES=1).
module tb_shuffle_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        do_preload = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  key1 = '0;
    logic [7:0]  read_data, address, write_data;
    logic [7:0]  read_data1, address1, write_data1;
    logic        write_enable, finish, write_enable1, finish1;

    logic [7:0]  mem [256];
    logic [7:0]  mem1 [256];
    logic [7:0]  addr_q, addr1_q;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mdl_s [256];
    logic [7:0]  mdl_j [256];
    int          mdl_ss;
    int          exp_lat, exp_wrs;
    int          lat, wrs, swap_bad;
    logic [7:0]  wa [6];
    logic [7:0]  wd [6];

    always #5 clk = ~clk;

    shuffle_responder #(.KEY_BYTES(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
        .read_data(read_data), .address(address), .write_data(write_data),
        .write_enable(write_enable), .finish(finish)
    );

    shuffle_responder #(.KEY_BYTES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .secret_key(key1),
        .read_data(read_data1), .address(address1), .write_data(write_data1),
        .write_enable(write_enable1), .finish(finish1)
    );

    // RAM: registered address, unregistered q.
    always @(posedge clk) begin
        addr_q  <= address;
        addr1_q <= address1;
        if (do_preload) begin
            for (int n = 0; n < 256; n++) begin
                mem[n]  <= 8'(n);
                mem1[n] <= 8'(n);
            end
        end else begin
            if (write_enable)  mem[address]   <= write_data;
            if (write_enable1) mem1[address1] <= write_data1;
        end
    end
    assign read_data  = mem[addr_q];
    assign read_data1 = mem1[addr1_q];

    // Software KSA over s[n]=n; also records j per iteration and self-swaps.
    task automatic run_model(input logic [127:0] key, input int nb);
        logic [7:0] j, t;
        j = 0;
        mdl_ss = 0;
        for (int n = 0; n < 256; n++) mdl_s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            j = j + mdl_s[n] + key[8*(nb-1-(n % nb)) +: 8];
            mdl_j[n] = j;
            if (j == 8'(n)) mdl_ss++;
            t = mdl_s[n];
            mdl_s[n] = mdl_s[j];
            mdl_s[j] = t;
        end
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
        exp_lat = 1792 - 2 * mdl_ss;
        exp_wrs = 512 - 2 * mdl_ss;
`else
        exp_lat = 1792;
        exp_wrs = 512;
`endif
    endtask

    task automatic preload();
        @(negedge clk);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
    endtask

    // Launch one run, watch every write against the model, stop at finish.
    // p1/p2: cycle counts after accept at which start is raised for one cycle.
    task automatic run_dut(input logic [23:0] key, input int p1, input int p2);
        int it;
        lat = 0; wrs = 0; swap_bad = 0; it = 0;
        @(negedge clk);
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        secret_key = ~key;
        while (lat < 4000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (write_enable) begin
                if (wrs < 6) begin
                    wa[wrs] = address;
                    wd[wrs] = write_data;
                end
                if (wrs % 2 == 0) begin
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
                    while (it < 255 && mdl_j[it] == 8'(it)) it++;
`endif
                    if (address !== 8'(it)) swap_bad++;
                end else begin
                    if (address !== mdl_j[it]) swap_bad++;
                    it++;
                end
                wrs++;
            end
            start = (lat == p1 || lat == p2);
            if (finish) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({address, write_data, write_enable, finish} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got addr=%h wd=%h we=%b fin=%b expected all 0",
                     address, write_data, write_enable, finish);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_zero_key();
        int diffs;
        run_model(128'h0, 3);
        preload();
        run_dut(24'h000000, -1, -1);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d expected %0d", lat, exp_lat);
        end
        n_cmp++;
        if (wrs !== exp_wrs) begin
            n_bad++;
            $display("FAIL zero_write_count: got %0d expected %0d", wrs, exp_wrs);
        end
        n_cmp++;
        if (swap_bad !== 0) begin
            n_bad++;
            $display("FAIL zero_swap_trace: got %0d bad writes expected 0", swap_bad);
        end
        // i=0: j=0, i=1: j=1, i=2: j=3 -> s[2]=3, s[3]=2
        n_cmp++;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
        if ({wa[0], wd[0], wa[1], wd[1]} !== {8'd2, 8'd3, 8'd3, 8'd2}) begin
`else
        if ({wa[0], wa[1], wa[2], wa[3], wa[4], wd[4], wa[5], wd[5]} !==
            {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2}) begin
`endif
            n_bad++;
            $display("FAIL zero_first_iters: got a=%h,%h,%h,%h,%h,%h d=%h,%h,%h,%h,%h,%h expected j=0,1,3 swap 2<->3",
                     wa[0], wa[1], wa[2], wa[3], wa[4], wa[5], wd[0], wd[1], wd[2], wd[3], wd[4], wd[5]);
        end
        diffs = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== mdl_s[n]) diffs++;
        n_cmp++;
        if (diffs !== 0) begin
            n_bad++;
            $display("FAIL zero_final_ram: got %0d differing bytes expected 0", diffs);
        end
    endtask

    task automatic test_lab_key();
        int diffs;
        run_model(128'h00033C, 3);
        preload();
        run_dut(24'h00033C, -1, -1);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL lab_latency: got %0d expected %0d", lat, exp_lat);
        end
        n_cmp++;
        if (swap_bad !== 0 || wrs !== exp_wrs) begin
            n_bad++;
            $display("FAIL lab_swap_trace: got %0d bad of %0d writes expected 0 bad of %0d",
                     swap_bad, wrs, exp_wrs);
        end
        diffs = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== mdl_s[n]) diffs++;
        n_cmp++;
        if (diffs !== 0) begin
            n_bad++;
            $display("FAIL lab_final_ram: got %0d differing bytes expected 0", diffs);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        int diffs;
        run_model(128'h0, 3);
        preload();
        run_dut(24'h000000, 100, exp_lat);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL busy_start_latency: got %0d expected %0d", lat, exp_lat);
        end
        @(posedge clk);
        #1 start = 1'b0;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (finish || write_enable || address != 8'd0) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL done_start_ignored: got %0d active cycles expected 0", extra);
        end
        run_model(128'h00033C, 3);
        preload();
        run_dut(24'h00033C, -1, -1);
        diffs = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== mdl_s[n]) diffs++;
        n_cmp++;
        if (lat !== exp_lat || diffs !== 0) begin
            n_bad++;
            $display("FAIL fresh_run: got latency %0d diffs %0d expected %0d and 0",
                     lat, diffs, exp_lat);
        end
    endtask

    task automatic test_reset_midrun();
        int fins;
        int diffs;
        run_model(128'h0, 3);
        preload();
        @(negedge clk);
        secret_key = 24'h000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({address, write_data, write_enable, finish} !== 18'd0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got addr=%h wd=%h we=%b fin=%b expected all 0",
                     address, write_data, write_enable, finish);
        end
        fins = 0;
        repeat (5) begin
            @(negedge clk);
            if (finish) fins++;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (finish) fins++;
        end
        n_cmp++;
        if (fins !== 0) begin
            n_bad++;
            $display("FAIL midrun_no_finish: got %0d finish cycles expected 0", fins);
        end
        preload();
        run_dut(24'h000000, -1, -1);
        diffs = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== mdl_s[n]) diffs++;
        n_cmp++;
        if (lat !== exp_lat || diffs !== 0) begin
            n_bad++;
            $display("FAIL restart_after_reset: got latency %0d diffs %0d expected %0d and 0",
                     lat, diffs, exp_lat);
        end
    endtask

    task automatic test_one_byte_key();
        int l1;
        int diffs;
        run_model(128'hFF, 1);
        preload();
        @(negedge clk);
        key1 = 8'hFF;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        key1 = 8'h00;
        l1 = 0;
        while (l1 < 4000) begin
            @(posedge clk);
            l1++;
            @(negedge clk);
            if (finish1) break;
        end
        n_cmp++;
        if (l1 !== exp_lat) begin
            n_bad++;
            $display("FAIL one_byte_latency: got %0d expected %0d", l1, exp_lat);
        end
        diffs = 0;
        for (int n = 0; n < 256; n++) if (mem1[n] !== mdl_s[n]) diffs++;
        n_cmp++;
        if (diffs !== 0) begin
            n_bad++;
            $display("FAIL one_byte_final_ram: got %0d differing bytes expected 0", diffs);
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_lab_key();
        test_start_ignored();
        test_reset_midrun();
        test_one_byte_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
